// File: rtl/day8_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package day8_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/day8_full_subtractor.sv
// Combinational one-bit full subtractor: d = x - y - bi, bo = borrow out.
module day8_full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/day8_serial_subtractor.sv
// LSB-first serial subtractor: one full-subtractor cell reused over WIDTH cycles,
// wrapped in a start/busy/done handshake with registered outputs.
module day8_serial_subtractor
  import day8_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             d;
  logic             bo;
  logic [WIDTH-1:0] d_full;

  day8_full_subtractor u_fs (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .bi (br),
    .d  (d),
    .bo (bo)
  );

  // d_full is the result register contents including the bit computed this cycle;
  // only the WIDTH-1 already-finished bits need storage.
  generate
    if (WIDTH == 1) begin : g_one
      assign d_full = d;
    end else begin : g_wide
      logic [WIDTH-2:0] d_sr;

      assign d_full = {d, d_sr};

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          d_sr <= '0;
        end else if (state == IDLE && start) begin
          d_sr <= '0;
        end else if (state == RUN) begin
          d_sr <= d_full[WIDTH-1:1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            br    <= bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          br   <= bo;
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            diff  <= d_full;
            bout  <= bo;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_day8_serial_subtractor.sv
// Directed bench for day8_serial_subtractor at WIDTH=8 and WIDTH=1.
module tb_day8_serial_subtractor;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       bout;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       bin8 = 1'b0;
  logic       busy8, done8, bout8;
  logic [7:0] diff8;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       bin1 = 1'b0;
  logic       busy1, done1, bout1;
  logic [0:0] diff1;

  int         total = 0;
  int         bad = 0;
  logic [7:0] lastDiff8 = '0;
  logic       lastBout8 = 1'b0;
  vec_t       vecs[8];

  always #5 clk = ~clk;

  day8_serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  day8_serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called just after a rising edge with the WIDTH=8 unit idle; returns just after
  // the edge that follows the done cycle.
  task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                               input int pulseCyc, output int doneCyc,
                               output int busyErr, output int heldErr);
    start8 = 1'b1;
    a8 = ta;
    b8 = tb;
    bin8 = tbin;
    doneCyc = -1;
    busyErr = 0;
    heldErr = 0;
    for (int cyc = 1; cyc <= 20 && doneCyc < 0; cyc++) begin
      @(posedge clk);
      #1;
      start8 = (cyc == pulseCyc);
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      bin8 = 1'($urandom);
      @(negedge clk);
      if (busy8 !== (cyc <= 8)) busyErr++;
      if (busy8 && done8) busyErr++;
      if (cyc <= 8 && (diff8 !== lastDiff8 || bout8 !== lastBout8)) heldErr++;
      if (done8 === 1'b1) doneCyc = cyc;
    end
    start8 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic runOp1(input logic ta, input logic tb, input logic tbin, output int doneCyc);
    start1 = 1'b1;
    a1 = ta;
    b1 = tb;
    bin1 = tbin;
    doneCyc = -1;
    for (int cyc = 1; cyc <= 10 && doneCyc < 0; cyc++) begin
      @(posedge clk);
      #1;
      start1 = 1'b0;
      a1 = ~ta;
      b1 = ~tb;
      bin1 = ~tbin;
      @(negedge clk);
      if (done1 === 1'b1) doneCyc = cyc;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int doneCyc, busyErr, heldErr;
    int firstDone, secondDone, seenDone;
    logic [7:0] firstDiff, secondDiff;
    logic firstBout, secondBout;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vecs[2] = '{8'h10, 8'h10, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};
    vecs[4] = '{8'h80, 8'h7F, 1'b0, 8'h01, 1'b0};
    vecs[5] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
    vecs[6] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0};
    vecs[7] = '{8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0};

    #1 rst = 1'b1;
    #1;
    checkOutput("reset busy", {31'd0, busy8}, 32'd0);
    checkOutput("reset done", {31'd0, done8}, 32'd0);
    checkOutput("reset diff", {24'd0, diff8}, 32'd0);
    checkOutput("reset bout", {31'd0, bout8}, 32'd0);
    checkOutput("reset w1 diff", {31'd0, diff1}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].bin, -1, doneCyc, busyErr, heldErr);
      checkOutput($sformatf("vec%0d diff", i), {24'd0, diff8}, {24'd0, vecs[i].diff});
      checkOutput($sformatf("vec%0d bout", i), {31'd0, bout8}, {31'd0, vecs[i].bout});
      checkOutput($sformatf("vec%0d done cycle", i), doneCyc, 32'd9);
      checkOutput($sformatf("vec%0d busy errors", i), busyErr, 32'd0);
      checkOutput($sformatf("vec%0d held errors", i), heldErr, 32'd0);
      checkOutput($sformatf("vec%0d done pulse width", i), {31'd0, done8}, 32'd0);
      lastDiff8 = vecs[i].diff;
      lastBout8 = vecs[i].bout;
    end

    // A start pulse in cycle 3 of a running operation must be dropped.
    applyStimulus(8'h5A, 8'h3C, 1'b0, 3, doneCyc, busyErr, heldErr);
    checkOutput("pulse diff", {24'd0, diff8}, 32'h1E);
    checkOutput("pulse bout", {31'd0, bout8}, 32'd0);
    checkOutput("pulse done cycle", doneCyc, 32'd9);
    checkOutput("pulse held errors", heldErr, 32'd0);
    checkOutput("pulse idle busy", {31'd0, busy8}, 32'd0);
    lastDiff8 = 8'h1E;
    lastBout8 = 1'b0;

    // Start held high through DONE: second operation is accepted in the next IDLE cycle.
    start8 = 1'b1;
    a8 = 8'h5A;
    b8 = 8'h3C;
    bin8 = 1'b0;
    firstDone = -1;
    secondDone = -1;
    firstDiff = '0;
    secondDiff = '0;
    firstBout = 1'b1;
    secondBout = 1'b1;
    for (int cyc = 1; cyc <= 30 && secondDone < 0; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 1) begin
        a8 = 8'h20;
        b8 = 8'h05;
      end
      if (cyc == 11) start8 = 1'b0;
      @(negedge clk);
      if (done8 === 1'b1) begin
        if (firstDone < 0) begin
          firstDone = cyc;
          firstDiff = diff8;
          firstBout = bout8;
        end else begin
          secondDone = cyc;
          secondDiff = diff8;
          secondBout = bout8;
        end
      end
    end
    start8 = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("b2b first done cycle", firstDone, 32'd9);
    checkOutput("b2b second done cycle", secondDone, 32'd19);
    checkOutput("b2b first diff", {24'd0, firstDiff}, 32'h1E);
    checkOutput("b2b first bout", {31'd0, firstBout}, 32'd0);
    checkOutput("b2b second diff", {24'd0, secondDiff}, 32'h1B);
    checkOutput("b2b second bout", {31'd0, secondBout}, 32'd0);
    checkOutput("b2b idle after", {30'd0, busy8, done8}, 32'd0);

    // Reset in cycle 4 of RUN abandons the operation.
    start8 = 1'b1;
    a8 = 8'h33;
    b8 = 8'h11;
    bin8 = 1'b0;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("pre-reset busy", {31'd0, busy8}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("midrun reset busy", {31'd0, busy8}, 32'd0);
    checkOutput("midrun reset done", {31'd0, done8}, 32'd0);
    checkOutput("midrun reset diff", {24'd0, diff8}, 32'd0);
    checkOutput("midrun reset bout", {31'd0, bout8}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seenDone = 0;
    repeat (15) begin
      @(negedge clk);
      if (done8 === 1'b1 || busy8 === 1'b1) seenDone++;
    end
    checkOutput("no done after reset", seenDone, 32'd0);
    @(posedge clk);
    #1;
    lastDiff8 = '0;
    lastBout8 = 1'b0;
    applyStimulus(8'hC3, 8'h3C, 1'b1, -1, doneCyc, busyErr, heldErr);
    checkOutput("post-reset diff", {24'd0, diff8}, 32'h86);
    checkOutput("post-reset bout", {31'd0, bout8}, 32'd0);
    checkOutput("post-reset done cycle", doneCyc, 32'd9);
    checkOutput("post-reset busy errors", busyErr, 32'd0);

    // WIDTH=1: exhaustive over a, b, bin.
    for (int i = 0; i < 8; i++) begin
      logic ta, tb, tbin;
      int r;
      ta = i[2];
      tb = i[1];
      tbin = i[0];
      r = int'(ta) - int'(tb) - int'(tbin);
      runOp1(ta, tb, tbin, doneCyc);
      checkOutput($sformatf("w1 case%0d diff", i), {31'd0, diff1}, r & 1);
      checkOutput($sformatf("w1 case%0d bout", i), {31'd0, bout1}, (r < 0) ? 32'd1 : 32'd0);
      checkOutput($sformatf("w1 case%0d done cycle", i), doneCyc, 32'd2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
